// File: rtl/feeder_pkg.sv
// Shared types and defaults for the serial bit feeder.
package feeder_pkg;
  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DIV   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    FIN   = 2'd3
  } state_e;
endpackage

// File: rtl/tick_gen.sv
// Hold-cycle counter: while enabled, counts 0..DIV-1 and ticks on the last
// count; held at zero whenever disabled so each enable starts a fresh bit.
module tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_en,
  output logic o_tick,
  output logic o_first
);
  localparam int CW = $clog2(DIV + 1);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  // Count while enabled, wrap after DIV-1, clear when disabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                   r_cnt <= '0;
    else if (!i_en || r_cnt == LAST) r_cnt <= '0;
    else                            r_cnt <= r_cnt + 1'b1;
  end

  assign o_tick  = i_en && (r_cnt == LAST);
  assign o_first = i_en && (r_cnt == '0);
endmodule

// File: rtl/serial_bit_feeder.sv
// Serial bit feeder: captures a WIDTH-bit pattern and plays it MSB first,
// each bit held DIV cycles, to a downstream sequence detector.
// Optional build macro SERIAL_BIT_FEEDER_LOOP_EN: replay the pattern
// continuously with a single FIN gap cycle until stop or reset.
module serial_bit_feeder
  import feeder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DIV   = DEFAULT_DIV
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] pattern,
  input  logic             start,
  input  logic             stop,
  output logic             w,
  output logic             w_valid,
  output logic             busy,
  output logic             done
);
  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  state_e           r_state;
  state_e           w_next;
  logic [WIDTH-1:0] r_pat;
  logic [BW-1:0]    r_bit;
  logic             w_run;
  logic             w_tick;
  logic             w_first;
  logic             w_last;
  logic             w_accept;

  assign w_run    = (r_state == RUN);
  assign w_last   = (r_bit == LAST_BIT);
  // Pattern is only writable while not emitting.
  assign w_accept = load && ((r_state == IDLE) || (r_state == ARMED));

  tick_gen #(.DIV(DIV)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .i_en    (w_run),
    .o_tick  (w_tick),
    .o_first (w_first)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Pattern store; kept across runs so a later start replays it from the MSB.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      r_pat <= '0;
    else if (w_accept) r_pat <= pattern;
  end

  // Bit counter (0 = MSB); parked at zero outside RUN so every run starts at the MSB.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    r_bit <= '0;
    else if (!w_run) r_bit <= '0;
    else if (w_tick) r_bit <= w_last ? '0 : r_bit + 1'b1;
  end

  // Next state and Moore outputs; stop outranks start, load/start ignored in RUN/FIN.
  always_comb begin
    w_next  = r_state;
    busy    = 1'b0;
    done    = 1'b0;
    w       = 1'b0;
    w_valid = 1'b0;
    case (r_state)
      IDLE:  if (load) w_next = ARMED;
      ARMED: if (start && !stop) w_next = RUN;
      RUN: begin
        busy    = 1'b1;
        w       = r_pat[LAST_BIT - r_bit];
        w_valid = w_first;
        if (stop)                  w_next = ARMED;
        else if (w_tick && w_last) w_next = FIN;
      end
      FIN: begin
        done = 1'b1;
`ifdef SERIAL_BIT_FEEDER_LOOP_EN
        w_next = stop ? ARMED : RUN;
`else
        w_next = ARMED;
`endif
      end
      default: w_next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_serial_bit_feeder.sv
// Bench for serial_bit_feeder: two instances (DIV=4 and DIV=1) share the
// stimulus; a queue-of-expected-outputs model predicts every cycle.
module tb_serial_bit_feeder;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic         load = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic [W-1:0] pattern = '0;
  logic [1:0]   w, w_valid, busy, done;

  always #5 clk = ~clk;

  serial_bit_feeder #(.WIDTH(W), .DIV(4)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .load(load), .pattern(pattern),
    .start(start), .stop(stop), .w(w[0]), .w_valid(w_valid[0]),
    .busy(busy[0]), .done(done[0]));

  serial_bit_feeder #(.WIDTH(W), .DIV(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .load(load), .pattern(pattern),
    .start(start), .stop(stop), .w(w[1]), .w_valid(w_valid[1]),
    .busy(busy[1]), .done(done[1]));

  int checks = 0;
  int failures = 0;

  // Model: per instance, queue of future {w,w_valid,busy,done}; empty = IDLE/ARMED.
  int           divs[2] = '{4, 1};
  logic [3:0]   q[2][$];
  logic         has_pat[2];
  logic [W-1:0] pat[2];
  logic [3:0]   obs[2];

  logic [W-1:0] cbits[2];
  int           cval[2], cfirst[2], cdone[2];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 50)
        $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
    end
  endfunction

  // One whole pattern emission followed by the FIN cycle.
  function automatic void push_seq(input int d, input logic [W-1:0] p);
    for (int b = W - 1; b >= 0; b--)
      for (int k = 0; k < divs[d]; k++)
        q[d].push_back({p[b], (k == 0), 1'b1, 1'b0});
    q[d].push_back(4'b0001);
  endfunction

  // One clock: compare at negedge, drive inputs, advance the model.
  task automatic cyc(input logic ld, input logic [W-1:0] pt, input logic st, input logic sp);
    logic [3:0] e;
    logic       was;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      e = (q[d].size() > 0) ? q[d][0] : 4'b0000;
      obs[d] = {w[d], w_valid[d], busy[d], done[d]};
      checks++;
      if (obs[d] !== e) begin
        failures++;
        if (failures <= 50)
          $display("FAIL cycle_dut%0d t=%0t actual=%b required=%b (w,vld,busy,done)", d, $time, obs[d], e);
      end
    end
    load = ld; pattern = pt; start = st; stop = sp;
    for (int d = 0; d < 2; d++) begin
      if (q[d].size() > 0) begin
        e = q[d].pop_front();
        if (e[1] && sp) q[d].delete();
`ifdef SERIAL_BIT_FEEDER_LOOP_EN
        else if (e[0] && !sp) push_seq(d, pat[d]);
`endif
      end else begin
        was = has_pat[d];
        if (ld) begin pat[d] = pt; has_pat[d] = 1'b1; end
        if (was && st && !sp) push_seq(d, pat[d]);
      end
    end
    @(posedge clk);
  endtask

  task automatic collect(input int n);
    for (int d = 0; d < 2; d++) begin
      cbits[d] = '0; cval[d] = 0; cfirst[d] = -1; cdone[d] = -1;
    end
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, '0, 1'b0, 1'b0);
      for (int d = 0; d < 2; d++)
        if (cdone[d] < 0) begin
          if (obs[d][2]) begin
            if (cfirst[d] < 0) cfirst[d] = i;
            cval[d]++;
            cbits[d] = {cbits[d][W-2:0], obs[d][3]};
          end
          if (obs[d][0]) cdone[d] = i;
        end
    end
  endtask

  // Called right after a posedge: asynchronous reset in mid-cycle.
  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("reset_async_outputs", 32'({w[d], w_valid[d], busy[d], done[d]}), 32'd0);
      q[d].delete(); has_pat[d] = 1'b0; pat[d] = '0;
    end
    load = 1'b0; start = 1'b0; stop = 1'b0;
    cyc(1'b0, '0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    int nv, nb, ndone;
    logic [W-1:0] rp;
    for (int d = 0; d < 2; d++) begin has_pat[d] = 1'b0; pat[d] = '0; end

    // Pin the model against hand-derived values.
    push_seq(0, 8'hB1);
    chk("model_len_div4", 32'(q[0].size()), 32'd33);
    chk("model_first_div4", 32'(q[0][0]), 32'b1110);
    chk("model_bit6_div4", 32'(q[0][4]), 32'b0110);
    chk("model_hold_div4", 32'(q[0][5]), 32'b0010);
    chk("model_fin_div4", 32'(q[0][32]), 32'b0001);
    push_seq(1, 8'hF0);
    chk("model_len_div1", 32'(q[1].size()), 32'd9);
    chk("model_bit4_div1", 32'(q[1][3]), 32'b1110);
    chk("model_bit3_div1", 32'(q[1][4]), 32'b0110);
    q[0].delete(); q[1].delete();

    // Power-on reset.
    #1 reset_n = 1'b0;
    cyc(1'b0, '0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("reset_state_dut0", 32'(obs[0]), 32'd0);
    #1 reset_n = 1'b1;

    // start in IDLE is ignored.
    nv = 0; nb = 0;
    for (int i = 0; i < 20; i++) begin
      rp = W'($urandom);
      cyc(1'b0, rp, 1'b1, 1'b0);
      for (int d = 0; d < 2; d++) begin nv += int'(obs[d][2]); nb += int'(obs[d][1]); end
    end
    chk("idle_start_valid", 32'(nv), 32'd0);
    chk("idle_start_busy", 32'(nb), 32'd0);

    // Single shot 8'hB1.
    cyc(1'b1, 8'hB1, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    collect(40);
    chk("b1_bits_div4", 32'(cbits[0]), 32'hB1);
    chk("b1_valids_div4", 32'(cval[0]), 32'd8);
    chk("b1_done_gap_div4", 32'(cdone[0] - cfirst[0]), 32'd32);
    chk("b1_bits_div1", 32'(cbits[1]), 32'hB1);
    chk("b1_done_gap_div1", 32'(cdone[1] - cfirst[1]), 32'd8);
    cyc(1'b0, '0, 1'b0, 1'b1);

    // DIV=1, 8'hF0: eight consecutive valid cycles.
    cyc(1'b1, 8'hF0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    collect(40);
    chk("f0_bits_div1", 32'(cbits[1]), 32'hF0);
    chk("f0_valids_div1", 32'(cval[1]), 32'd8);
    chk("f0_span_div1", 32'(cdone[1] - cfirst[1]), 32'd8);
    cyc(1'b0, '0, 1'b0, 1'b1);

    // Load+start together in ARMED over an old 8'hFF.
    cyc(1'b1, 8'hFF, 1'b0, 1'b0);
    cyc(1'b1, 8'h0F, 1'b1, 1'b0);
    collect(40);
    chk("ldst_first4_div4", 32'(cbits[0][7:4]), 32'h0);
    chk("ldst_bits_div4", 32'(cbits[0]), 32'h0F);
    cyc(1'b0, '0, 1'b0, 1'b1);

    // Stop on run cycle 10 of 8'hAA, then replay.
    cyc(1'b1, 8'hAA, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    ndone = 0;
    for (int i = 0; i < 9; i++) begin
      cyc(1'b0, '0, 1'b0, 1'b0);
      ndone += int'(obs[0][0]);
    end
    cyc(1'b0, '0, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("stop_outputs_div4", 32'(obs[0]), 32'd0);
    chk("stop_no_done_div4", 32'(ndone), 32'd0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    collect(40);
    chk("stop_replay_div4", 32'(cbits[0]), 32'hAA);
    chk("stop_replay_valids", 32'(cval[0]), 32'd8);
    cyc(1'b0, '0, 1'b0, 1'b1);

    // Reset mid-run; afterwards start alone must do nothing.
    rp = W'($urandom);
    cyc(1'b1, rp, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
`ifdef SERIAL_BIT_FEEDER_LOOP_EN
    for (int i = 0; i < 80; i++) cyc(1'b0, '0, 1'b0, 1'b0);
`else
    for (int i = 0; i < 15; i++) cyc(1'b0, '0, 1'b0, 1'b0);
`endif
    do_reset();
    cyc(1'b0, '0, 1'b1, 1'b0);
    collect(5);
    chk("post_reset_start_ignored", 32'(cval[0] + cval[1]), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 999) < 3) begin
        do_reset();
      end else begin
        rp = W'($urandom);
        cyc(($urandom_range(0, 9) == 0), rp, ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 39) == 0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
